sums_lane_streamer: RTL

Consumer-side unpacker for the wide accumulator result buses produced by the convolution base block, such as the 18-lane × 44-bit third-kernel sums bus. It snapshots one result bus on a valid pulse, then emits its lanes one at a time over a valid/ready stream. Each lane is rescaled by an arithmetic right shift and narrowed to the datapath word width. It sits between the base block outputs and the feature-map writeback path. It replaces the practice of leaving the sums buses unconsumed.

---
 rtl/sums_lane_streamer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sums_lane_streamer.sv
// rtl/sums_lane_streamer.sv - snapshots a wide accumulator sums bus and streams its rescaled lanes
// Optional saturation on narrowing: define SUMS_STREAM_SAT_EN (default build truncates).
module sums_lane_streamer #(
  parameter int LANES      = 18,
  parameter int LANE_BITS  = 44,
  parameter int OUT_BITS   = 16,
  parameter int FRAC_SHIFT = 12,
  localparam int IDX_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LANES*LANE_BITS-1:0] sums_in,
  input  logic                       sums_valid,
  output logic                       sums_ready,
  output logic [OUT_BITS-1:0]        m_data,
  output logic [IDX_W-1:0]           m_index,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       sat_flag,
  output logic [15:0]                drop_cnt
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                     state, state_next;
  logic [LANES*LANE_BITS-1:0] snapshot;
  logic                       capture;
  logic                       advance;
  logic [IDX_W-1:0]           next_idx;
  logic [LANE_BITS-1:0]       lane_src;
  logic [OUT_BITS-1:0]        lane_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    advance    = 1'b0;
    sums_ready = 1'b0;
    m_valid    = 1'b0;
    case (state)
      IDLE: begin
        sums_ready = 1'b1;
        if (sums_valid) begin
          capture    = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (m_last) state_next = IDLE;
          else        advance    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign next_idx = m_index + IDX_W'(1);

  // Lane 0 comes straight from the bus on capture; later lanes from the snapshot.
  always_comb begin
    lane_src = sums_in[LANE_BITS-1:0];
    if (!capture) begin
      for (int k = 0; k < LANES; k++) begin
        if (next_idx == IDX_W'(k)) lane_src = snapshot[k*LANE_BITS +: LANE_BITS];
      end
    end
  end

`ifdef SUMS_STREAM_SAT_EN
  logic signed [LANE_BITS-1:0]  shifted;
  logic [LANE_BITS-OUT_BITS:0]  upper;
  logic                         lane_sat;

  // The value fits only if every bit from the output sign bit upward agrees.
  always_comb begin
    shifted  = $signed(lane_src) >>> FRAC_SHIFT;
    upper    = shifted[LANE_BITS-1:OUT_BITS-1];
    lane_sat = !((&upper) || !(|upper));
    if (!lane_sat)                lane_out = shifted[OUT_BITS-1:0];
    else if (shifted[LANE_BITS-1]) lane_out = {1'b1, {(OUT_BITS-1){1'b0}}};
    else                          lane_out = {1'b0, {(OUT_BITS-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sat_flag <= 1'b0;
    else if (capture) sat_flag <= lane_sat;
    else if (advance) sat_flag <= sat_flag | lane_sat;
  end
`else
  assign lane_out = OUT_BITS'($signed(lane_src) >>> FRAC_SHIFT);
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot <= '0;
      m_data   <= '0;
      m_index  <= '0;
      m_last   <= 1'b0;
    end else if (capture) begin
      snapshot <= sums_in;
      m_data   <= lane_out;
      m_index  <= '0;
      m_last   <= (LANES == 1);
    end else if (advance) begin
      m_data   <= lane_out;
      m_index  <= next_idx;
      m_last   <= (next_idx == IDX_W'(LANES - 1));
    end
  end

  // Pulses arriving while a bus is still streaming are lost; count them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (sums_valid && (state == STREAM) && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end

endmodule
